// File: rtl/merge_pkg.sv
// Shared definitions for the N-input clocked merge: arbitration mode encodings.
package merge_pkg;

    localparam int MERGE_SEL = 0;
    localparam int MERGE_RR  = 1;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } merge_mode_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular-buffer FIFO with occupancy count; push ignored when full,
// pop ignored when empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == LVL_W'(DEPTH));
    assign empty    = (count == '0);
    assign level    = count;
    assign pop_data = mem[rd_ptr];
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;

    // Storage is not reset: the count alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/merge_n_clocked.sv
// N-input packet merge into a buffered output, steered either by a select-token
// stream or by a round-robin arbiter.
module merge_n_clocked
    import merge_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_IN  = 4,
    parameter int DEPTH = 2,
    parameter int MODE  = MERGE_SEL,
    parameter int SEL_W = $clog2(N_IN)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_IN-1:0]            in_valid,
    output logic [N_IN-1:0]            in_ready,
    input  logic [N_IN*WIDTH-1:0]      in_data,
    input  logic                       sel_valid,
    output logic                       sel_ready,
    input  logic [SEL_W-1:0]           sel_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       err_sel
);

    localparam merge_mode_e ARB_MODE = (MODE == MERGE_RR) ? MODE_RR : MODE_SEL;

    logic             full;
    logic             empty;
    logic             push;
    logic [WIDTH-1:0] push_data;
    logic [SEL_W-1:0] take_idx;
    logic             sel_in_range;
    logic             sel_pkt_valid;
    logic [SEL_W-1:0] rr_ptr;
    logic [N_IN-1:0]  valid_rot;
    logic [SEL_W:0]   offset;
    logic [SEL_W:0]   grant_sum;
    logic [SEL_W-1:0] grant;
    logic             grant_valid;

    assign sel_in_range = ({1'b0, sel_data} < (SEL_W + 1)'(N_IN));

    always_comb begin
        sel_pkt_valid = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (sel_data == SEL_W'(i)) begin
                sel_pkt_valid = in_valid[i];
            end
        end
    end

    // Rotate so bit 0 is the pointer's channel; the lowest set bit is the nearest requester.
    assign valid_rot = N_IN'({in_valid, in_valid} >> rr_ptr);

    always_comb begin
        offset      = '0;
        grant_valid = |valid_rot;
        for (int k = N_IN - 1; k >= 0; k--) begin
            if (valid_rot[k]) begin
                offset = (SEL_W + 1)'(k);
            end
        end
        grant_sum = {1'b0, rr_ptr} + offset;
        if (grant_sum >= (SEL_W + 1)'(N_IN)) begin
            grant_sum = grant_sum - (SEL_W + 1)'(N_IN);
        end
        grant = grant_sum[SEL_W-1:0];
    end

    // Ready never looks at out_ready: a full FIFO blocks pushes even on a popping cycle.
    always_comb begin
        in_ready  = '0;
        sel_ready = 1'b0;
        take_idx  = '0;
        if (ARB_MODE == MODE_RR) begin
            take_idx = grant;
            for (int i = 0; i < N_IN; i++) begin
                in_ready[i] = !reset && !full && grant_valid && (grant == SEL_W'(i));
            end
        end else begin
            take_idx  = sel_data;
            sel_ready = !reset && (!sel_in_range || (!full && sel_pkt_valid));
            for (int i = 0; i < N_IN; i++) begin
                in_ready[i] = !reset && !full && sel_valid && sel_pkt_valid
                              && (sel_data == SEL_W'(i));
            end
        end
    end

    always_comb begin
        push_data = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (take_idx == SEL_W'(i)) begin
                push_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign push = |(in_valid & in_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr  <= '0;
            err_sel <= 1'b0;
        end else begin
            err_sel <= (ARB_MODE == MODE_SEL) && sel_valid && sel_ready && !sel_in_range;
            if (ARB_MODE == MODE_RR && push) begin
                rr_ptr <= (grant == SEL_W'(N_IN - 1)) ? '0 : grant + SEL_W'(1);
            end
        end
    end

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (out_ready),
        .pop_data  (out_data),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    assign out_valid = !empty;

endmodule

// File: tb/tb_merge_n_clocked.sv
// Directed bench: select mode at N_IN=4 and N_IN=3, round-robin at N_IN=4, all DEPTH=2.
module tb_merge_n_clocked;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Select-mode instance, N_IN=4
    logic [3:0]  s_in_valid, s_in_ready;
    logic [31:0] s_in_data;
    logic        s_sel_valid, s_sel_ready, s_out_valid, s_out_ready, s_err;
    logic [1:0]  s_sel_data, s_level;
    logic [7:0]  s_out_data;

    // Select-mode instance, N_IN=3
    logic [2:0]  t_in_valid, t_in_ready;
    logic [23:0] t_in_data;
    logic        t_sel_valid, t_sel_ready, t_out_valid, t_out_ready, t_err;
    logic [1:0]  t_sel_data, t_level;
    logic [7:0]  t_out_data;

    // Round-robin instance, N_IN=4
    logic [3:0]  r_in_valid, r_in_ready;
    logic [31:0] r_in_data;
    logic        r_sel_valid, r_sel_ready, r_out_valid, r_out_ready, r_err;
    logic [1:0]  r_sel_data, r_level;
    logic [7:0]  r_out_data;

    merge_n_clocked #(.WIDTH(8), .N_IN(4), .DEPTH(2), .MODE(0)) dut_sel4 (
        .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data(s_in_data), .sel_valid(s_sel_valid), .sel_ready(s_sel_ready),
        .sel_data(s_sel_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_data(s_out_data), .level(s_level), .err_sel(s_err));

    merge_n_clocked #(.WIDTH(8), .N_IN(3), .DEPTH(2), .MODE(0)) dut_sel3 (
        .clk(clk), .reset(reset), .in_valid(t_in_valid), .in_ready(t_in_ready),
        .in_data(t_in_data), .sel_valid(t_sel_valid), .sel_ready(t_sel_ready),
        .sel_data(t_sel_data), .out_valid(t_out_valid), .out_ready(t_out_ready),
        .out_data(t_out_data), .level(t_level), .err_sel(t_err));

    merge_n_clocked #(.WIDTH(8), .N_IN(4), .DEPTH(2), .MODE(1)) dut_rr4 (
        .clk(clk), .reset(reset), .in_valid(r_in_valid), .in_ready(r_in_ready),
        .in_data(r_in_data), .sel_valid(r_sel_valid), .sel_ready(r_sel_ready),
        .sel_data(r_sel_data), .out_valid(r_out_valid), .out_ready(r_out_ready),
        .out_data(r_out_data), .level(r_level), .err_sel(r_err));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        s_in_valid = 4'hF; s_in_data = 32'hA3A2A1A0; s_sel_valid = 1'b1; s_sel_data = 2'd1;
        s_out_ready = 1'b1;
        t_in_valid = 3'h7; t_in_data = 24'h323130; t_sel_valid = 1'b1; t_sel_data = 2'd3;
        t_out_ready = 1'b1;
        r_in_valid = 4'hF; r_in_data = 32'hC3C2C1C0; r_sel_valid = 1'b0; r_sel_data = 2'd0;
        r_out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (s_in_ready !== 4'h0) begin
            errors++; $display("[TB] FAIL reset_in_ready: got %h expected 0", s_in_ready);
        end
        checks++;
        if (s_sel_ready !== 1'b0 || t_sel_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_sel_ready: got %b%b expected 00", s_sel_ready, t_sel_ready);
        end
        checks++;
        if (r_in_ready !== 4'h0) begin
            errors++; $display("[TB] FAIL reset_rr_ready: got %h expected 0", r_in_ready);
        end
        checks++;
        if (s_level !== 2'd0 || s_out_valid !== 1'b0 || t_err !== 1'b0 || r_out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_state: level=%0d out_valid=%b err=%b rr_valid=%b expected 0 0 0 0",
                               s_level, s_out_valid, t_err, r_out_valid);
        end
        s_in_valid = 4'h0; s_sel_valid = 1'b0;
        t_in_valid = 3'h0; t_sel_valid = 1'b0;
        r_in_valid = 4'h0;
        reset = 1'b0;
        tick();
    endtask

    // Tokens 2,0,3 with every input valid: one packet per cycle, in token order.
    task automatic test_sel_order();
        logic [1:0] seq [3] = '{2'd2, 2'd0, 2'd3};
        logic [7:0] exp [3] = '{8'hA2, 8'hA0, 8'hA3};
        s_in_valid = 4'hF;
        s_out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s_sel_valid = 1'b1;
            s_sel_data  = seq[k];
            #1;
            checks++;
            if (s_in_ready !== (4'b0001 << seq[k]) || s_sel_ready !== 1'b1) begin
                errors++; $display("[TB] FAIL sel_order_ready[%0d]: got in_ready=%b sel_ready=%b expected %b 1",
                                   k, s_in_ready, s_sel_ready, 4'b0001 << seq[k]);
            end
            tick();
            checks++;
            if (s_out_valid !== 1'b1 || s_out_data !== exp[k] || s_level !== 2'd1) begin
                errors++; $display("[TB] FAIL sel_order_out[%0d]: got valid=%b data=%h level=%0d expected 1 %h 1",
                                   k, s_out_valid, s_out_data, s_level, exp[k]);
            end
        end
        s_sel_valid = 1'b0;
        s_in_valid  = 4'h0;
        tick();
        checks++;
        if (s_out_valid !== 1'b0 || s_level !== 2'd0) begin
            errors++; $display("[TB] FAIL sel_order_drain: got valid=%b level=%0d expected 0 0", s_out_valid, s_level);
        end
    endtask

    // Token waits for its packet; neither side is consumed alone.
    task automatic test_sel_wait();
        s_sel_valid = 1'b1;
        s_sel_data  = 2'd1;
        s_in_valid  = 4'b1101;
        s_in_data   = 32'hA3A255A0;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (s_sel_ready !== 1'b0 || s_in_ready !== 4'h0 || s_level !== 2'd0) begin
                errors++; $display("[TB] FAIL sel_wait[%0d]: got sel_ready=%b in_ready=%b level=%0d expected 0 0000 0",
                                   k, s_sel_ready, s_in_ready, s_level);
            end
            tick();
        end
        s_in_valid = 4'b1111;
        #1;
        checks++;
        if (s_sel_ready !== 1'b1 || s_in_ready !== 4'b0010) begin
            errors++; $display("[TB] FAIL sel_wait_take: got sel_ready=%b in_ready=%b expected 1 0010",
                               s_sel_ready, s_in_ready);
        end
        tick();
        s_sel_valid = 1'b0;
        s_in_valid  = 4'h0;
        checks++;
        if (s_out_valid !== 1'b1 || s_out_data !== 8'h55) begin
            errors++; $display("[TB] FAIL sel_wait_out: got valid=%b data=%h expected 1 55", s_out_valid, s_out_data);
        end
        tick();
        s_in_data = 32'hA3A2A1A0;
    endtask

    // N_IN=3: index 3 is out of range and must be dropped with a one-cycle error pulse.
    task automatic test_sel_range();
        t_sel_valid = 1'b1;
        t_sel_data  = 2'd3;
        t_in_valid  = 3'h7;
        #1;
        checks++;
        if (t_sel_ready !== 1'b1 || t_in_ready !== 3'h0) begin
            errors++; $display("[TB] FAIL range_drop: got sel_ready=%b in_ready=%b expected 1 000", t_sel_ready, t_in_ready);
        end
        tick();
        t_sel_valid = 1'b0;
        checks++;
        if (t_err !== 1'b1 || t_level !== 2'd0) begin
            errors++; $display("[TB] FAIL range_err: got err=%b level=%0d expected 1 0", t_err, t_level);
        end
        tick();
        checks++;
        if (t_err !== 1'b0 || t_level !== 2'd0) begin
            errors++; $display("[TB] FAIL range_err_clear: got err=%b level=%0d expected 0 0", t_err, t_level);
        end
        t_sel_valid = 1'b1;
        t_sel_data  = 2'd2;
        tick();
        t_sel_valid = 1'b0;
        t_in_valid  = 3'h0;
        checks++;
        if (t_out_valid !== 1'b1 || t_out_data !== 8'h32 || t_err !== 1'b0) begin
            errors++; $display("[TB] FAIL range_top_index: got valid=%b data=%h err=%b expected 1 32 0",
                               t_out_valid, t_out_data, t_err);
        end
        tick();
    endtask

    // Round robin from ptr=0; a lone requester wins repeatedly; rotation resumes after it.
    task automatic test_rr();
        logic [3:0] vtab [13] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF,
                                  4'h4, 4'h4, 4'h4,
                                  4'hF, 4'hF, 4'hF, 4'hF};
        int         gtab [13] = '{0, 1, 2, 3, 0, 1, 2, 2, 2, 3, 0, 1, 2};
        r_out_ready = 1'b1;
        for (int k = 0; k < 13; k++) begin
            r_in_valid = vtab[k];
            #1;
            checks++;
            if (r_in_ready !== (4'b0001 << gtab[k]) || r_sel_ready !== 1'b0) begin
                errors++; $display("[TB] FAIL rr_grant[%0d]: got in_ready=%b sel_ready=%b expected %b 0",
                                   k, r_in_ready, r_sel_ready, 4'b0001 << gtab[k]);
            end
            tick();
            checks++;
            if (r_out_valid !== 1'b1 || r_out_data !== (8'hC0 + 8'(gtab[k])) || r_level !== 2'd1) begin
                errors++; $display("[TB] FAIL rr_out[%0d]: got valid=%b data=%h level=%0d expected 1 %h 1",
                                   k, r_out_valid, r_out_data, r_level, 8'hC0 + 8'(gtab[k]));
            end
        end
        r_in_valid = 4'h0;
        tick();
    endtask

    // Two packets fill DEPTH=2; full blocks pushes even when out_ready pops that cycle.
    task automatic test_backpressure();
        s_in_valid  = 4'hF;
        s_out_ready = 1'b0;
        s_sel_valid = 1'b1;
        s_sel_data  = 2'd0;
        tick();
        s_sel_data = 2'd1;
        #1;
        checks++;
        if (s_in_ready !== 4'b0010 || s_level !== 2'd1) begin
            errors++; $display("[TB] FAIL bp_second: got in_ready=%b level=%0d expected 0010 1", s_in_ready, s_level);
        end
        tick();
        s_sel_data = 2'd2;
        #1;
        checks++;
        if (s_level !== 2'd2 || s_in_ready !== 4'h0 || s_sel_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL bp_full: got level=%0d in_ready=%b sel_ready=%b expected 2 0000 0",
                               s_level, s_in_ready, s_sel_ready);
        end
        tick();
        checks++;
        if (s_out_valid !== 1'b1 || s_out_data !== 8'hA0 || s_level !== 2'd2) begin
            errors++; $display("[TB] FAIL bp_stall: got valid=%b data=%h level=%0d expected 1 a0 2",
                               s_out_valid, s_out_data, s_level);
        end
        s_out_ready = 1'b1;
        #1;
        checks++;
        if (s_in_ready !== 4'h0) begin
            errors++; $display("[TB] FAIL bp_no_comb_path: got in_ready=%b expected 0000", s_in_ready);
        end
        tick();
        checks++;
        if (s_out_data !== 8'hA1 || s_level !== 2'd1 || s_in_ready !== 4'b0100) begin
            errors++; $display("[TB] FAIL bp_drain1: got data=%h level=%0d in_ready=%b expected a1 1 0100",
                               s_out_data, s_level, s_in_ready);
        end
        tick();
        s_sel_valid = 1'b0;
        s_in_valid  = 4'h0;
        checks++;
        if (s_out_data !== 8'hA2 || s_level !== 2'd1) begin
            errors++; $display("[TB] FAIL bp_drain2: got data=%h level=%0d expected a2 1", s_out_data, s_level);
        end
        tick();
        checks++;
        if (s_out_valid !== 1'b0 || s_level !== 2'd0) begin
            errors++; $display("[TB] FAIL bp_empty: got valid=%b level=%0d expected 0 0", s_out_valid, s_level);
        end
    endtask

    // Reset with a full FIFO and a moved RR pointer, then confirm a clean restart.
    task automatic test_reset_mid();
        s_in_valid  = 4'hF;
        s_out_ready = 1'b0;
        s_sel_valid = 1'b1;
        s_sel_data  = 2'd0;
        r_out_ready = 1'b0;
        r_in_valid  = 4'b0010;
        tick();
        s_sel_data = 2'd1;
        r_in_valid = 4'h0;
        tick();
        checks++;
        if (s_level !== 2'd2 || r_level !== 2'd1) begin
            errors++; $display("[TB] FAIL rmid_setup: got s_level=%0d r_level=%0d expected 2 1", s_level, r_level);
        end
        reset       = 1'b1;
        s_sel_valid = 1'b0;
        tick();
        checks++;
        if (s_out_valid !== 1'b0 || s_level !== 2'd0 || r_out_valid !== 1'b0 || r_level !== 2'd0) begin
            errors++; $display("[TB] FAIL rmid_cleared: got s=%b/%0d r=%b/%0d expected 0/0 0/0",
                               s_out_valid, s_level, r_out_valid, r_level);
        end
        reset       = 1'b0;
        r_in_valid  = 4'hF;
        r_out_ready = 1'b1;
        s_sel_valid = 1'b1;
        s_sel_data  = 2'd3;
        s_out_ready = 1'b1;
        #1;
        checks++;
        if (r_in_ready !== 4'b0001 || s_in_ready !== 4'b1000) begin
            errors++; $display("[TB] FAIL rmid_restart_ready: got r=%b s=%b expected 0001 1000", r_in_ready, s_in_ready);
        end
        tick();
        r_in_valid  = 4'h0;
        s_sel_valid = 1'b0;
        s_in_valid  = 4'h0;
        checks++;
        if (s_out_valid !== 1'b1 || s_out_data !== 8'hA3 || s_level !== 2'd1 || r_out_data !== 8'hC0) begin
            errors++; $display("[TB] FAIL rmid_restart_out: got valid=%b data=%h level=%0d rr=%h expected 1 a3 1 c0",
                               s_out_valid, s_out_data, s_level, r_out_data);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_sel_order();
        test_sel_wait();
        test_sel_range();
        test_rr();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
